// File: rtl/uart_tx_param_pkg.sv
// uart_tx_param_pkg: shared state encoding, parity codes and parameter checks for uart_tx_param
package uart_tx_param_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    function automatic logic has_parity(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction
    function automatic bit params_ok(input int data_w, input int oversample, input int fifo_depth);
        return data_w >= 5 && data_w <= 9 && oversample >= 4 && oversample <= 64 &&
               fifo_depth >= 2 && fifo_depth <= 16 && (fifo_depth & (fifo_depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous word FIFO feeding the transmit shifter
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic push, pop;
    always_comb begin
        push = wr && !full;
        pop = rd && !empty;
    end
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout = mem[rp];
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter with selectable parity and stop bits
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_bd,
    input  logic [DATA_W-1:0] datain,
    input  logic              wrsig,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic              tx
);
    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

    if (!params_ok(DATA_W, OVERSAMPLE, FIFO_DEPTH)) begin : g_bad_params
        $error("uart_tx_param: illegal DATA_W/OVERSAMPLE/FIFO_DEPTH");
    end

    tx_state_t state;
    logic [TW-1:0] tick;
    logic [BW-1:0] bit_idx;
    logic [DATA_W-1:0] sh, head;
    logic par_l, par_en, stop2_l, empty, push, pop, tick_last;

    // A pop either starts a frame from idle or chains the next one onto the last stop tick.
    always_comb begin
        push = wrsig && !full;
        tick_last = clk_bd && tick == ((state == STOP && stop2_l) ? STOP2_LAST : BIT_LAST);
        pop = !empty && (state == IDLE || (state == STOP && tick_last));
    end

    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr(wrsig),
        .din(datain),
        .rd(pop),
        .dout(head),
        .full(full),
        .empty(empty)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) overflow <= 1'b0;
        else if (wrsig && full) overflow <= 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tick <= '0;
            bit_idx <= '0;
            sh <= '0;
            par_l <= 1'b0;
            par_en <= 1'b0;
            stop2_l <= 1'b0;
            tx <= 1'b1;
            busy <= 1'b0;
        end else if (pop) begin
            state <= START;
            tick <= '0;
            sh <= head;
            par_l <= ^head ^ (parity_mode == PAR_ODD);
            par_en <= has_parity(parity_mode);
            stop2_l <= stop2;
            tx <= 1'b0;
            busy <= 1'b1;
        end else if (state == IDLE) begin
            busy <= push;
        end else if (clk_bd) begin
            tick <= tick_last ? '0 : tick + TW'(1);
            if (tick_last)
                case (state)
                    START: begin
                        state <= DATA;
                        bit_idx <= '0;
                        tx <= sh[0];
                        sh <= sh >> 1;
                    end
                    DATA: begin
                        if (bit_idx == DATA_LAST) begin
                            state <= par_en ? PARITY : STOP;
                            tx <= par_en ? par_l : 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            tx <= sh[0];
                            sh <= sh >> 1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        busy <= push;
                    end
                endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized and directed frames checked against a bit-level line model
module tb_uart_tx_param;
    logic clk = 1'b0, rst = 1'b1, clk_bd = 1'b0, wrsig = 1'b0, wr7 = 1'b0, stop2 = 1'b0;
    logic rec = 1'b0, use7 = 1'b0;
    logic [7:0] datain = '0;
    logic [6:0] datain7 = '0;
    logic [1:0] parity_mode = '0;
    logic full, overflow, busy, tx, full7, overflow7, busy7, tx7;
    logic exp_q[$];
    logic obs_q[$];
    int total = 0, bad = 0;

    uart_tx_param dut (
        .clk(clk), .rst(rst), .clk_bd(clk_bd), .datain(datain), .wrsig(wrsig),
        .parity_mode(parity_mode), .stop2(stop2), .full(full), .overflow(overflow),
        .busy(busy), .tx(tx)
    );

    uart_tx_param #(.DATA_W(7)) dut7 (
        .clk(clk), .rst(rst), .clk_bd(clk_bd), .datain(datain7), .wrsig(wr7),
        .parity_mode(parity_mode), .stop2(stop2), .full(full7), .overflow(overflow7),
        .busy(busy7), .tx(tx7)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        clk_bd = ($urandom_range(0, 1) != 0);
    end

    // One line sample per baud tick, taken before the edge that consumes the tick.
    always @(negedge clk)
        if (rec && clk_bd) obs_q.push_back(use7 ? tx7 : tx);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] d, input int w, input logic [1:0] m, input logic s2);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (m == 2'b01 || m == 2'b10) exp_q.push_back(((ones % 2) == 1) ^ (m == 2'b10));
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endfunction

    function automatic bit strip();
        while (obs_q.size() > 0 && obs_q[0] !== 1'b0) void'(obs_q.pop_front());
        return obs_q.size() > 0;
    endfunction

    task automatic start_rec();
        obs_q.delete();
        rec = 1'b1;
    endtask

    task automatic wait_samples(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20000 && !ok; t++) begin
            @(posedge clk);
            ok = strip() && obs_q.size() >= n;
        end
    endtask

    task automatic write(input logic [7:0] d);
        @(posedge clk);
        #1;
        if (use7) begin
            datain7 = d[6:0];
            wr7 = 1'b1;
        end else begin
            datain = d;
            wrsig = 1'b1;
        end
        @(posedge clk);
        #1;
        wrsig = 1'b0;
        wr7 = 1'b0;
    endtask

    task automatic check_line(input string tag);
        bit ok;
        int n;
        logic [15:0] v;
        n = exp_q.size();
        wait_samples(n * 16, ok);
        chk({tag, "_timeout"}, 32'(ok), 32'd1);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 16; k++) v[k] = obs_q[i * 16 + k];
                chk($sformatf("%s_bit%0d", tag, i), 32'(v), exp_q[i] ? 32'hFFFF : 32'h0);
            end
            #1;
            chk({tag, "_busy_end"}, 32'(use7 ? busy7 : busy), 32'd0);
        end
        rec = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit ok;
        int zeros;
        logic [7:0] d;
        logic [1:0] m;
        logic s;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_tx7", 32'(tx7), 32'd1);
        chk("rst_busy7", 32'(busy7), 32'd0);
        rst = 1'b0;

        parity_mode = 2'b01;
        stop2 = 1'b0;
        start_rec();
        write(8'h55);
        push_frame(8'h55, 8, 2'b01, 1'b0);
        check_line("f55_even");

        parity_mode = 2'b10;
        start_rec();
        write(8'h07);
        push_frame(8'h07, 8, 2'b10, 1'b0);
        check_line("f07_odd");

        parity_mode = 2'b01;
        start_rec();
        write(8'h07);
        push_frame(8'h07, 8, 2'b01, 1'b0);
        check_line("f07_even");

        parity_mode = 2'b11;
        start_rec();
        write(8'h07);
        push_frame(8'h07, 8, 2'b11, 1'b0);
        check_line("f07_mode3");

        parity_mode = 2'b01;
        stop2 = 1'b1;
        start_rec();
        write(8'hA3);
        push_frame(8'hA3, 8, 2'b01, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        stop2 = 1'b0;
        write(8'h5C);
        push_frame(8'h5C, 8, 2'b01, 1'b0);
        write(8'h3A);
        push_frame(8'h3A, 8, 2'b01, 1'b0);
        check_line("stop2_switch");

        parity_mode = 2'b00;
        chk("ovf_pre", 32'(overflow), 32'd0);
        start_rec();
        write(8'h10);
        push_frame(8'h10, 8, 2'b00, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            datain = 8'(8'h11 + i);
            wrsig = 1'b1;
            @(posedge clk);
            #1;
            if (i == 3) chk("full_after4", 32'(full), 32'd1);
            if (i < 4) push_frame(8'(8'h11 + i), 8, 2'b00, 1'b0);
        end
        wrsig = 1'b0;
        chk("overflow_set", 32'(overflow), 32'd1);
        check_line("burst");

        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom);
            m = 2'($urandom);
            s = 1'($urandom);
            parity_mode = m;
            stop2 = s;
            start_rec();
            write(d);
            push_frame(d, 8, m, s);
            repeat (3) @(posedge clk);
            #1;
            parity_mode = 2'($urandom);
            stop2 = 1'($urandom);
            check_line($sformatf("rnd%0d", r));
        end

        parity_mode = 2'b00;
        stop2 = 1'b0;
        start_rec();
        write(8'hF0);
        write(8'h81);
        write(8'h42);
        wait_samples(72, ok);
        chk("rst_mid_wait", 32'(ok), 32'd1);
        #1;
        chk("pre_rst_bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_rec();
        repeat (300) @(posedge clk);
        #1;
        zeros = 0;
        foreach (obs_q[i]) if (obs_q[i] !== 1'b1) zeros++;
        chk("no_tx_after_rst", 32'(zeros), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        rec = 1'b0;

        parity_mode = 2'b10;
        start_rec();
        write(8'h3C);
        push_frame(8'h3C, 8, 2'b10, 1'b0);
        check_line("post_rst");

        parity_mode = 2'b00;
        use7 = 1'b1;
        start_rec();
        write(8'h7F);
        push_frame(8'h7F, 7, 2'b00, 1'b0);
        check_line("w7_7f");
        chk("w7_full", 32'(full7), 32'd0);
        chk("w7_ovf", 32'(overflow7), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning clk_bd ticks per bit period (legal 4..64).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning words buffered ahead of the shifter (power of 2, 2..16).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 clk_bd  input  1  one-clk-wide baud enable at OVERSAMPLE x baud rate.
REQ-008 datain  input  DATA_W  word to transmit, LSB first.
REQ-009 wrsig  input  1  write strobe; each clk with wrsig=1 and full=0 pushes datain.
REQ-010 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-012 full  output  1  FIFO holds FIFO_DEPTH words.
REQ-013 overflow  output  1  sticky; set when wrsig=1 while full=1.
REQ-014 busy  output  1  frame in progress or FIFO non-empty.
REQ-015 tx  output  1  serial line, idle high.

Function
REQ-016 States: IDLE, START, DATA, PARITY, STOP; each bit held for exactly OVERSAMPLE clk_bd ticks.
REQ-017 IDLE with FIFO non-empty: pop head on that edge, latch word, parity_mode and stop2, tx<=0, enter START.
REQ-018 START -> DATA after OVERSAMPLE ticks; DATA shifts bit0..bit(DATA_W-1), one per bit period.
REQ-019 DATA -> PARITY if latched mode even/odd, else -> STOP; parity bit = XOR of data (even) or its inverse (odd).
REQ-020 STOP holds tx=1 for OVERSAMPLE (stop2=0) or 2xOVERSAMPLE (stop2=1) ticks.
REQ-021 STOP end with FIFO non-empty: pop and enter START on same edge (no idle gap); else IDLE.
REQ-022 Changes to parity_mode/stop2 mid-frame SHALL not affect the frame in progress.
REQ-023 Write when full SHALL be dropped, even if a pop occurs on same edge; overflow<=1.
REQ-024 Write to empty FIFO in IDLE: popped on the next clk edge; tx falls 1 clk after the write edge.
REQ-025 Simultaneous push and pop when not full: both take effect, count unchanged.
REQ-026 Bit-tick counter width = clog2(2xOVERSAMPLE); clk_bd ignored in IDLE.
REQ-027 busy = (state != IDLE) | FIFO non-empty, registered with state.

Reset
REQ-028 On rst=1, immediately: tx=1, busy=0, full=0, overflow=0, state IDLE, FIFO empty, counters 0.
REQ-029 Reset mid-frame SHALL abort the frame and discard FIFO contents; no partial bits after release.
REQ-030 First frame after reset release requires a new write.

Structure
REQ-031 Shared package holds state encoding, parity_mode codes (PAR_NONE/PAR_EVEN/PAR_ODD), and parameter range checks.
REQ-032 One sub-module uart_tx_fifo (synchronous FIFO, DATA_W x FIFO_DEPTH, full/empty, async reset).

Verification
REQ-033 DATA_W=8, OVERSAMPLE=16, even, stop2=0, write 0x55 -> tx: 0,1,0,1,0,1,0,1,0, parity 0, stop 1; each bit 16 ticks; busy falls after stop.
REQ-034 Same but odd parity, write 0x07 -> parity bit 0; with even -> 1; mode 11 -> no parity bit, frame 10 bits.
REQ-035 FIFO_DEPTH=4, five writes 0x11..0x15 in consecutive clks while busy -> full=1 after 4th, 0x15 dropped, overflow=1; 0x11..0x14 sent back-to-back with no idle gap.
REQ-036 stop2=1, write 0xA3 then change stop2 to 0 mid-frame -> frame ends with 32-tick stop; next frame uses 16-tick stop.
REQ-037 Assert rst during DATA bit 3 with 2 words queued -> tx=1, busy=0, full=0 same cycle; no transmission after release until new write.
REQ-038 DATA_W=7, none, write 0x7F -> 9-bit frame: start 0, seven 1s, stop 1.
